// File: rtl/vram_axi_rd_slave_if.sv
`default_nettype none
// ============================================================================
// Module   : vram_axi_rd_slave_if
// Function : AXI4 read address / read data channel bundle (32-bit data).
// Revision : 1.0
// ============================================================================
interface vram_axi_rd_slave_if;
    logic [31:0] ARADDR;
    logic [7:0]  ARLEN;
    logic        ARVALID;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY;

    modport slave (
        input  ARADDR, ARLEN, ARVALID, RREADY,
        output ARREADY, RDATA, RRESP, RLAST, RVALID
    );

    modport master (
        output ARADDR, ARLEN, ARVALID, RREADY,
        input  ARREADY, RDATA, RRESP, RLAST, RVALID
    );
endinterface
`default_nettype wire

// File: rtl/vram_axi_rd_slave.sv
`default_nettype none
// ============================================================================
// Module   : vram_axi_rd_slave
// Function : AXI4 INCR read-burst responder over a single-clock VRAM array.
//            Optional out-of-range check: define VRAM_RD_OOR_CHECK_EN.
// Revision : 1.0
// ============================================================================
module vram_axi_rd_slave #(
    parameter int unsigned ADDR_W    = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  wire                ACLK,
    input  wire                ARESETN,
    vram_axi_rd_slave_if.slave axi,
    input  wire                WREN,
    input  wire  [ADDR_W-1:0]  WRADDR,
    input  wire  [31:0]        WRDATA,
    output logic               BUSY
);
    localparam int unsigned c_DEPTH  = 2**ADDR_W;
`ifdef VRAM_RD_OOR_CHECK_EN
    localparam int unsigned c_IDX_W  = 30;
`else
    localparam int unsigned c_IDX_W  = ADDR_W;
`endif
    localparam int unsigned      c_BEAT_W  = 35;
    localparam logic [c_IDX_W-1:0] c_IDX_ONE = c_IDX_W'(1);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_FETCH = 2'd1;
    localparam logic [1:0] c_S_BURST = 2'd2;

    logic [31:0]         r_mem [0:c_DEPTH-1];
    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic                r_arready;
    logic [c_IDX_W-1:0]  r_widx;
    logic [8:0]          r_fetch_left;
    logic                r_out_vld;
    logic [c_BEAT_W-1:0] r_out_beat;
    logic                r_skid_vld;
    logic [c_BEAT_W-1:0] r_skid_beat;

    logic                w_busy;
    logic                w_active;
    logic                w_ar_hs;
    logic                w_pop;
    logic                w_rd;
    logic                w_rd_last;
    logic                w_out_free;
    logic [31:0]         w_off;
    logic [31:0]         w_mem_word;
    logic [c_BEAT_W-1:0] w_rd_beat;
    logic                w_unused;

    assign w_off      = axi.ARADDR - BASE_ADDR;
    assign w_ar_hs    = axi.ARVALID & r_arready;
    assign w_pop      = r_out_vld & axi.RREADY;
    assign w_out_free = ~r_out_vld | w_pop;
    assign w_rd_last  = (r_fetch_left == 9'd1);
    assign w_mem_word = r_mem[r_widx[ADDR_W-1:0]];

    // A fetch is only issued when the output register or the skid can take it.
    assign w_rd = w_active & (r_fetch_left != 9'd0)
                & ~(r_out_vld & r_skid_vld & ~w_pop);

`ifdef VRAM_RD_OOR_CHECK_EN
    logic w_oor;
    assign w_oor     = |r_widx[c_IDX_W-1:ADDR_W];
    assign w_rd_beat = {w_rd_last, (w_oor ? 2'b10 : 2'b00), (w_oor ? 32'h0 : w_mem_word)};
    assign w_unused  = &{1'b0, w_off[1:0]};
`else
    assign w_rd_beat = {w_rd_last, 2'b00, w_mem_word};
    assign w_unused  = &{1'b0, w_off[31:ADDR_W+2], w_off[1:0]};
`endif

    always_ff @(posedge ACLK) begin
        if (WREN) begin
            r_mem[WRADDR] <= WRDATA;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE:  if (w_ar_hs) w_state_nxt = c_S_FETCH;
            c_S_FETCH: w_state_nxt = c_S_BURST;
            c_S_BURST: if (w_pop && r_out_beat[34]) w_state_nxt = c_S_IDLE;
            default:   w_state_nxt = c_S_IDLE;
        endcase
    end

    always_comb begin
        w_busy   = (r_state != c_S_IDLE);
        w_active = (r_state == c_S_FETCH) || (r_state == c_S_BURST);
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_arready    <= 1'b0;
            r_widx       <= '0;
            r_fetch_left <= 9'd0;
        end else begin
            r_arready <= (w_state_nxt == c_S_IDLE);
            if (w_ar_hs) begin
                r_widx       <= w_off[c_IDX_W+1:2];
                r_fetch_left <= {1'b0, axi.ARLEN} + 9'd1;
            end else if (w_rd) begin
                r_widx       <= r_widx + c_IDX_ONE;
                r_fetch_left <= r_fetch_left - 9'd1;
            end
        end
    end

    // Array word lands in the output register when it is free, else in the skid.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_out_vld   <= 1'b0;
            r_out_beat  <= '0;
            r_skid_vld  <= 1'b0;
            r_skid_beat <= '0;
        end else if (w_out_free) begin
            if (r_skid_vld) begin
                r_out_vld  <= 1'b1;
                r_out_beat <= r_skid_beat;
                r_skid_vld <= w_rd;
                if (w_rd) begin
                    r_skid_beat <= w_rd_beat;
                end
            end else if (w_rd) begin
                r_out_vld  <= 1'b1;
                r_out_beat <= w_rd_beat;
            end else begin
                r_out_vld  <= 1'b0;
            end
        end else if (w_rd) begin
            r_skid_vld  <= 1'b1;
            r_skid_beat <= w_rd_beat;
        end
    end

    assign axi.ARREADY = r_arready;
    assign axi.RVALID  = r_out_vld;
    assign axi.RDATA   = r_out_beat[31:0];
    assign axi.RRESP   = r_out_beat[33:32];
    assign axi.RLAST   = r_out_beat[34];
    assign BUSY        = w_busy;
endmodule
`default_nettype wire

// File: tb/tb_vram_axi_rd_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_vram_axi_rd_slave
// Function : Directed + randomized bench for vram_axi_rd_slave with a
//            behavioural burst model.
// Revision : 1.0
// ============================================================================
module tb_vram_axi_rd_slave;
    localparam int          ADDR_W = 10;
    localparam int          DEPTH  = 1024;
    localparam logic [31:0] BASE   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wren;
    logic [9:0]  wraddr;
    logic [31:0] wrdata;
    logic        busy;

    logic [31:0] model [DEPTH];
    int          n_assert = 0;
    int          n_fail   = 0;

    vram_axi_rd_slave_if axi();

    vram_axi_rd_slave #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
        .ACLK    (clk),
        .ARESETN (rst_n),
        .axi     (axi),
        .WREN    (wren),
        .WRADDR  (wraddr),
        .WRDATA  (wrdata),
        .BUSY    (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int idx, input logic [31:0] data);
        wren   = 1'b1;
        wraddr = 10'(idx);
        wrdata = data;
        tick();
        wren   = 1'b0;
        model[idx] = data;
    endtask

    // Expected {RLAST, RRESP, RDATA} for beat k of a burst starting at addr.
    function automatic logic [34:0] exp_beat(input logic [31:0] addr, input int k, input int len);
        logic [31:0] off;
        logic        lst;
        off = addr + 32'(4 * k) - BASE;
        lst = (k == len);
`ifdef VRAM_RD_OOR_CHECK_EN
        if (off >= 32'(4 * DEPTH)) return {lst, 2'b10, 32'h0};
`endif
        return {lst, 2'b00, model[off[ADDR_W+1:2]]};
    endfunction

    task automatic run_burst(input logic [31:0] addr, input int len, input int pct, input int abort_at);
        logic [34:0] expq[$];
        logic [34:0] beat, held, e;
        bit          stalled;
        int          cyc, got, first;
        for (int k = 0; k <= len; k++) expq.push_back(exp_beat(addr, k, len));
        axi.ARADDR  = addr;
        axi.ARLEN   = 8'(len);
        axi.ARVALID = 1'b1;
        cyc = 0;
        while (axi.ARREADY !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("ar_accept", 64'(axi.ARREADY), 64'd1);
        tick();
        axi.ARVALID = 1'b0;
        chk("busy_fetch", 64'(busy), 64'd1);
        cyc = 1; got = 0; first = -1; stalled = 1'b0; held = '0;
        while (got <= len && cyc < 3000) begin
            if (got == abort_at) break;
            beat = {axi.RLAST, axi.RRESP, axi.RDATA};
            if (stalled) chk("stall_hold", {axi.RVALID, beat}, {1'b1, held});
            axi.RREADY = ($urandom_range(99) < pct);
            stalled = 1'b0;
            if (axi.RVALID === 1'b1) begin
                if (first < 0) first = cyc;
                if (axi.RREADY) begin
                    e = expq.pop_front();
                    chk($sformatf("beat%0d@%0h", got, addr), 64'(beat), 64'(e));
                    got++;
                end else begin
                    stalled = 1'b1;
                    held    = beat;
                end
            end
            tick();
            cyc++;
        end
        if (abort_at < 0) begin
            axi.RREADY = 1'b0;
            chk("beat_count", 64'(got), 64'(len + 1));
            chk("first_latency", 64'(first), 64'd2);
            if (pct >= 100) chk("no_bubbles", 64'(cyc), 64'(len + 3));
            chk("arready_after", 64'(axi.ARREADY), 64'd1);
            chk("rvalid_after", 64'(axi.RVALID), 64'd0);
            chk("busy_after", 64'(busy), 64'd0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        wren = 1'b0; wraddr = '0; wrdata = '0;
        axi.ARADDR = '0; axi.ARLEN = '0; axi.ARVALID = 1'b1; axi.RREADY = 1'b0;

        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rst_arready", 64'(axi.ARREADY), 64'd0);
            chk("rst_rvalid", 64'(axi.RVALID), 64'd0);
        end
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_rdata", 64'(axi.RDATA), 64'd0);
        chk("rst_rresp", 64'(axi.RRESP), 64'd0);
        chk("rst_rlast", 64'(axi.RLAST), 64'd0);
        axi.ARVALID = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("arready_release", 64'(axi.ARREADY), 64'd1);

        for (int i = 0; i < DEPTH; i++) wr(i, 32'(i));
        wr(5, 32'hDEAD_BEEF);
        wr(1022, $urandom);
        wr(1023, $urandom);
        wr(0, $urandom);
        wr(1, $urandom);

        run_burst(32'h14, 0, 100, -1);
        run_burst(32'h80, 31, 100, -1);
        run_burst(32'h80, 31, 50, -1);
        run_burst(32'hFF8, 3, 100, -1);

        for (int i = 0; i < 24; i++) wr($urandom_range(DEPTH - 1), $urandom);
        for (int i = 0; i < 12; i++) begin
            a = {20'h0, 10'($urandom_range(DEPTH - 1)), 2'($urandom_range(3))};
            run_burst(a, $urandom_range(15), $urandom_range(30, 100), -1);
        end
        run_burst(32'h0, 255, 100, -1);

        run_burst(32'h80, 31, 100, 10);
        axi.RREADY = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_rvalid", 64'(axi.RVALID), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_arready", 64'(axi.ARREADY), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("midrst_arready_release", 64'(axi.ARREADY), 64'd1);
        chk("midrst_rvalid_release", 64'(axi.RVALID), 64'd0);
        run_burst(32'h14, 0, 100, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
